// File: rtl/jzjpcc_fetch_queue_if.sv
// Instruction-memory fetch channel between the fetch queue (master) and the memory (slave).
// Requests are in order, and the memory answers them in order, at least one cycle after acceptance.
interface jzjpcc_fetch_queue_if #(
    parameter int PC_MAX_B = 15
);
    logic                imem_req;
    logic [PC_MAX_B:2]   imem_addr;
    logic                imem_ready;
    logic                imem_rvalid;
    logic [31:2]         imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/jzjpcc_fetch_queue.sv
// Prefetching instruction fetch queue. A credit counter caps requests so the queue can never overflow.
// A redirect turns in-flight requests into a drop count, so their late responses are discarded.
module jzjpcc_fetch_queue #(
    parameter int                PC_MAX_B    = 15,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [PC_MAX_B:2] RESET_PC    = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    jzjpcc_fetch_queue_if.master  imem,
    input  logic                  pcCTWriteEnable,
    input  logic [PC_MAX_B:2]     controlTransferNewPC,
    input  logic                  stall_decode,
    output logic [31:2]           instruction_decode,
    output logic [PC_MAX_B:2]     currentPC_decode,
    output logic                  valid_decode
);
    localparam int PC_W  = PC_MAX_B - 1;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:2]      NOP     = 30'h0000_0004;
    localparam logic [CNT_W+1:0] DEPTH_C = (CNT_W + 2)'(QUEUE_DEPTH);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

    typedef struct packed {
        logic [31:2]       instr;
        logic [PC_MAX_B:2] pc;
    } entry_t;

    entry_t             mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, outstanding, drop;
    logic [PC_MAX_B:2]  fetch_pc, rsp_pc;

    logic [CNT_W+1:0]   credit_used;
    logic [CNT_W:0]     inflight;
    logic [CNT_W-1:0]   drop_on_redirect;
    logic               accept, fill, discard, pop;

    // NOTE: every signal below gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        credit_used    = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop};
        imem.imem_req  = !reset && !pcCTWriteEnable && (credit_used < DEPTH_C);
        imem.imem_addr = fetch_pc;
        accept         = imem.imem_req && imem.imem_ready;
        discard        = imem.imem_rvalid && (drop != '0);
        fill           = imem.imem_rvalid && (drop == '0) && (outstanding != '0);
        pop            = !stall_decode && (count != '0);
        inflight       = {1'b0, drop} + {1'b0, outstanding};
        // A response arriving with the redirect consumes one in-flight slot, which is why one is subtracted.
        if (imem.imem_rvalid && (inflight != '0)) begin
            drop_on_redirect = CNT_W'(inflight - (CNT_W + 1)'(1));
        end else begin
            drop_on_redirect = CNT_W'(inflight);
        end
    end

    // NOTE: state updates use non-blocking assignments, so every branch reads the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc           <= RESET_PC;
            rsp_pc             <= RESET_PC;
            count              <= '0;
            outstanding        <= '0;
            drop               <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            instruction_decode <= NOP;
            currentPC_decode   <= RESET_PC;
            valid_decode       <= 1'b0;
            // NOTE: the storage is cleared together with the block, so nothing from before reset can resurface.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pcCTWriteEnable) begin
            fetch_pc           <= controlTransferNewPC;
            rsp_pc             <= controlTransferNewPC;
            count              <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            outstanding        <= '0;
            drop               <= drop_on_redirect;
            instruction_decode <= NOP;
            valid_decode       <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_ONE;
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(fill);
            if (discard) begin
                drop <= drop - CNT_W'(1);
            end
            if (fill) begin
                mem[wr_ptr] <= '{instr: imem.imem_rdata, pc: rsp_pc};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                rsp_pc      <= rsp_pc + PC_ONE;
            end
            // The head is read from pre-edge storage, so an entry written this edge pops one edge later.
            count <= count + CNT_W'(fill) - CNT_W'(pop);
            if (!stall_decode) begin
                if (count != '0) begin
                    instruction_decode <= mem[rd_ptr].instr;
                    currentPC_decode   <= mem[rd_ptr].pc;
                    valid_decode       <= 1'b1;
                    rd_ptr             <= rd_ptr + PTR_W'(1);
                end else begin
                    instruction_decode <= NOP;
                    valid_decode       <= 1'b0;
                end
            end
        end
    end
endmodule
